// File: rtl/fpu_exception_responder.sv
// FPU exception responder: accepts one FP8 operation, classifies both operands,
// and either produces the IEEE special result (NaN, signed inf, signed zero) or
// hands the request to the arithmetic datapath (OUT_SPECIAL=0). It also keeps
// sticky NV/DZ flags and a saturating count of exceptions it has responded to.
// Response timing: accept at edge t, operands classified at edge t+1, and the
// response register loaded at edge t+2. The response is held until OUT_READY.
module fpu_exception_responder #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int CNT_W = 8,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       FP_OPERATION,
   input  logic [W-1:0]     OP_A,
   input  logic [W-1:0]     OP_B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             OUT_SPECIAL,
   output logic [W-1:0]     OUT_RESULT,
   output logic             OP_IS_EXCEPTION,
   output logic             FLAG_NV,
   output logic             FLAG_DZ,
   input  logic             FLAG_CLR,
   output logic [CNT_W-1:0] EXC_COUNT
);

   typedef enum logic [1:0] {IDLE, CLASSIFY, RESPOND}       state_t;
   typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_FIN} cls_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV}  fop_t;

   // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   state_t           state, state_d;
   fop_t             op_q;
   logic [W-1:0]     a_q, b_q;
   cls_t             cls_a, cls_b;
   logic             accept, handshake;

   logic             dec_special, dec_nv, dec_dz;
   logic [W-1:0]     dec_result;
   logic             rsp_nv, rsp_dz;

   function automatic cls_t classify(input logic [W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = x[W-2 -: EXP_W];
      m = x[MAN_W-1:0];
      if (e == '0 && m == '0)      return CLS_ZERO;
      else if (e == '1 && m == '0) return CLS_INF;
      else if (e == '1)            return CLS_NAN;
      else                         return CLS_FIN;   // includes subnormals
   endfunction

   function automatic logic [W-1:0] inf_of(input logic s);
      return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   endfunction

   assign IN_READY        = (state == IDLE);
   assign accept          = IN_VALID & IN_READY;
   assign handshake       = OUT_VALID & OUT_READY;
   assign OP_IS_EXCEPTION = rsp_nv | rsp_dz;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_d;
   end

   // Next-state: one cycle to classify, then wait in RESPOND for the handshake.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (IN_VALID) state_d = CLASSIFY;
         CLASSIFY: state_d = RESPOND;
         RESPOND:  if (handshake) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Request capture; only taken in IDLE so a busy responder ignores IN_VALID.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q <= OP_ADD;
         a_q  <= '0;
         b_q  <= '0;
      end else if (accept) begin
         op_q <= fop_t'(FP_OPERATION);
         a_q  <= OP_A;
         b_q  <= OP_B;
      end
   end

   // Operand classification register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cls_a <= CLS_ZERO;
         cls_b <= CLS_ZERO;
      end else if (state == CLASSIFY) begin
         cls_a <= classify(a_q);
         cls_b <= classify(b_q);
      end
   end

   // Special-case decision, first match wins. For sub the B sign is inverted
   // so add and sub share one rule set; mul/div use the product sign s.
   always_comb begin
      logic sa, sb, s;
      dec_special = 1'b0;
      dec_result  = '0;
      dec_nv      = 1'b0;
      dec_dz      = 1'b0;
      sa = a_q[W-1];
      sb = b_q[W-1] ^ (op_q == OP_SUB);
      s  = a_q[W-1] ^ b_q[W-1];
      if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
         dec_special = 1'b1;
         dec_result  = QNAN;
      end else begin
         case (op_q)
            OP_ADD, OP_SUB: begin
               if (cls_a == CLS_INF && cls_b == CLS_INF && sa != sb) begin
                  dec_special = 1'b1;
                  dec_result  = QNAN;
                  dec_nv      = 1'b1;
               end else if (cls_a == CLS_INF) begin
                  dec_special = 1'b1;
                  dec_result  = inf_of(sa);
               end else if (cls_b == CLS_INF) begin
                  dec_special = 1'b1;
                  dec_result  = inf_of(sb);
               end
            end
            OP_MUL: begin
               if ((cls_a == CLS_ZERO && cls_b == CLS_INF) ||
                   (cls_a == CLS_INF  && cls_b == CLS_ZERO)) begin
                  dec_special = 1'b1;
                  dec_result  = QNAN;
                  dec_nv      = 1'b1;
               end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
                  dec_special = 1'b1;
                  dec_result  = inf_of(s);
               end
            end
            default: begin // OP_DIV
               if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                   (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
                  dec_special = 1'b1;
                  dec_result  = QNAN;
                  dec_nv      = 1'b1;
               end else if (cls_a == CLS_FIN && cls_b == CLS_ZERO) begin
                  dec_special = 1'b1;
                  dec_result  = inf_of(s);
                  dec_dz      = 1'b1;
               end else if (cls_a == CLS_INF) begin
                  dec_special = 1'b1;
                  dec_result  = inf_of(s);
               end else if (cls_a == CLS_FIN && cls_b == CLS_INF) begin
                  dec_special = 1'b1;
                  dec_result  = {s, {(W-1){1'b0}}};
               end
            end
         endcase
      end
   end

   // Response register: loaded on the first RESPOND cycle, held until taken.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT_VALID   <= 1'b0;
         OUT_SPECIAL <= 1'b0;
         OUT_RESULT  <= '0;
         rsp_nv      <= 1'b0;
         rsp_dz      <= 1'b0;
      end else if (state == RESPOND && !OUT_VALID) begin
         OUT_VALID   <= 1'b1;
         OUT_SPECIAL <= dec_special;
         OUT_RESULT  <= dec_result;
         rsp_nv      <= dec_nv;
         rsp_dz      <= dec_dz;
      end else if (handshake) begin
         OUT_VALID   <= 1'b0;
         OUT_SPECIAL <= 1'b0;
         OUT_RESULT  <= '0;
         rsp_nv      <= 1'b0;
         rsp_dz      <= 1'b0;
      end
   end

   // Sticky flags: a setting handshake beats a same-cycle clear.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         FLAG_NV <= 1'b0;
         FLAG_DZ <= 1'b0;
      end else begin
         FLAG_NV <= (FLAG_NV & ~FLAG_CLR) | (handshake & rsp_nv);
         FLAG_DZ <= (FLAG_DZ & ~FLAG_CLR) | (handshake & rsp_dz);
      end
   end

   // Saturating exception counter, counted at the response handshake.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         EXC_COUNT <= '0;
      else if (handshake && OP_IS_EXCEPTION && EXC_COUNT != '1)
         EXC_COUNT <= EXC_COUNT + CNT_W'(1);
   end

endmodule

// File: tb/tb_fpu_exception_responder.sv
// Self-checking bench for fpu_exception_responder: directed vector table,
// randomized operations against a value-level reference model, and hand
// sequences for stall, flag clear, mid-operation reset and counter saturation.
module tb_fpu_exception_responder;

   logic       CLK, RST;
   logic       IN_VALID, IN_READY;
   logic [1:0] FP_OPERATION;
   logic [7:0] OP_A, OP_B;
   logic       OUT_VALID, OUT_READY, OUT_SPECIAL;
   logic [7:0] OUT_RESULT;
   logic       OP_IS_EXCEPTION, FLAG_NV, FLAG_DZ, FLAG_CLR;
   logic [7:0] EXC_COUNT;

   int total = 0;
   int bad   = 0;

   // Expected sticky state, advanced at every response handshake.
   logic       m_nv, m_dz;
   int         m_cnt;

   fpu_exception_responder #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) dut (
      .CLK(CLK), .RST(RST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_SPECIAL(OUT_SPECIAL), .OUT_RESULT(OUT_RESULT),
      .OP_IS_EXCEPTION(OP_IS_EXCEPTION),
      .FLAG_NV(FLAG_NV), .FLAG_DZ(FLAG_DZ), .FLAG_CLR(FLAG_CLR),
      .EXC_COUNT(EXC_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a, b;
      logic       sp;
      logic [7:0] res;
      logic       nv, dz;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: classify by value, infinities as +1/-1 directions for add/sub.
   function automatic logic [10:0] ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      logic an, ai, az, bn, bi, bz, af, bf, s, sbe;
      int   da, db;
      an = (a[6:3] == 4'hF) && (a[2:0] != 0);
      bn = (b[6:3] == 4'hF) && (b[2:0] != 0);
      ai = (a[6:0] == 7'h78);
      bi = (b[6:0] == 7'h78);
      az = (a[6:0] == 0);
      bz = (b[6:0] == 0);
      af = !an && !ai && !az;
      bf = !bn && !bi && !bz;
      s  = a[7] ^ b[7];
      if (an || bn) return {1'b1, 8'h7C, 2'b00};
      if (op < 2) begin
         sbe = b[7] ^ op[0];
         da = ai ? (a[7] ? -1 : 1) : 0;
         db = bi ? (sbe ? -1 : 1) : 0;
         if (da * db == -1)      return {1'b1, 8'h7C, 2'b10};
         if (da + db > 0)        return {1'b1, 8'h78, 2'b00};
         if (da + db < 0)        return {1'b1, 8'hF8, 2'b00};
         return 11'h0;
      end
      if (op == 2) begin
         if ((az && bi) || (ai && bz)) return {1'b1, 8'h7C, 2'b10};
         if (ai || bi)                 return {1'b1, s ? 8'hF8 : 8'h78, 2'b00};
         return 11'h0;
      end
      if ((az && bz) || (ai && bi)) return {1'b1, 8'h7C, 2'b10};
      if (af && bz)                 return {1'b1, s ? 8'hF8 : 8'h78, 2'b01};
      if (ai)                       return {1'b1, s ? 8'hF8 : 8'h78, 2'b00};
      if (af && bi)                 return {1'b1, s ? 8'h80 : 8'h00, 2'b00};
      return 11'h0;
   endfunction

   // One full transaction: accept, latency check, response check, optional
   // stall of 'stall' cycles (optionally poking IN_VALID), handshake, sticky state.
   task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic e_sp, input logic [7:0] e_res, input logic e_nv, input logic e_dz,
                        input int stall, input logic clr, input logic poke);
      int n;
      n = 0;
      while (!IN_READY && n < 10) begin @(posedge CLK); #1; n++; end
      chk("in_ready_before", IN_READY, 1);
      FP_OPERATION = op; OP_A = a; OP_B = b; IN_VALID = 1;
      @(posedge CLK); #1;
      IN_VALID = 0;
      chk("busy_after_accept", {IN_READY, OUT_VALID}, 2'b00);
      @(posedge CLK); #1;
      chk("valid_low_t1", OUT_VALID, 0);
      @(posedge CLK); #1;
      chk("valid_high_t2", OUT_VALID, 1);
      n = 0;
      while (!OUT_VALID && n < 8) begin @(posedge CLK); #1; n++; end
      chk("special", OUT_SPECIAL, e_sp);
      chk("result", OUT_RESULT, e_res);
      chk("op_is_exc", OP_IS_EXCEPTION, e_nv | e_dz);
      for (int i = 0; i < stall; i++) begin
         if (poke) begin
            FP_OPERATION = 2'b11; OP_A = 8'h00; OP_B = 8'h00; IN_VALID = 1;
         end
         @(posedge CLK); #1;
         chk("stall_stable", {OUT_VALID, OUT_SPECIAL, OUT_RESULT, OP_IS_EXCEPTION, IN_READY},
             {1'b1, e_sp, e_res, e_nv | e_dz, 1'b0});
      end
      IN_VALID = 0;
      OUT_READY = 1; FLAG_CLR = clr;
      @(posedge CLK); #1;
      OUT_READY = 0; FLAG_CLR = 0;
      m_nv = clr ? e_nv : (m_nv | e_nv);
      m_dz = clr ? e_dz : (m_dz | e_dz);
      if ((e_nv | e_dz) && m_cnt < 255) m_cnt++;
      chk("valid_dropped", OUT_VALID, 0);
      chk("flag_nv", FLAG_NV, m_nv);
      chk("flag_dz", FLAG_DZ, m_dz);
      chk("exc_count", EXC_COUNT, m_cnt);
      chk("ready_after", IN_READY, 1);
   endtask

   task automatic check_reset_state(input string nm);
      chk(nm, {IN_READY, OUT_VALID, OUT_SPECIAL, OUT_RESULT, OP_IS_EXCEPTION, FLAG_NV, FLAG_DZ, EXC_COUNT},
          {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
   endtask

   logic [7:0] pool[10];

   initial begin
      logic [10:0] r;
      logic [1:0]  op;
      logic [7:0]  a, b;

      vt[0]  = '{2'b00, 8'h78, 8'hF8, 1, 8'h7C, 1, 0};
      vt[1]  = '{2'b11, 8'h38, 8'h00, 1, 8'h78, 0, 1};
      vt[2]  = '{2'b11, 8'hB8, 8'h00, 1, 8'hF8, 0, 1};
      vt[3]  = '{2'b10, 8'h38, 8'h40, 0, 8'h00, 0, 0};
      vt[4]  = '{2'b01, 8'h78, 8'h78, 1, 8'h7C, 1, 0};
      vt[5]  = '{2'b01, 8'h78, 8'hF8, 1, 8'h78, 0, 0};
      vt[6]  = '{2'b00, 8'h79, 8'h38, 1, 8'h7C, 0, 0};
      vt[7]  = '{2'b10, 8'h00, 8'hF8, 1, 8'h7C, 1, 0};
      vt[8]  = '{2'b10, 8'hB8, 8'h78, 1, 8'hF8, 0, 0};
      vt[9]  = '{2'b11, 8'h00, 8'h80, 1, 8'h7C, 1, 0};
      vt[10] = '{2'b11, 8'hF8, 8'h78, 1, 8'h7C, 1, 0};
      vt[11] = '{2'b11, 8'hF8, 8'h38, 1, 8'hF8, 0, 0};
      vt[12] = '{2'b11, 8'h38, 8'hF8, 1, 8'h80, 0, 0};
      vt[13] = '{2'b11, 8'h00, 8'h38, 0, 8'h00, 0, 0};
      vt[14] = '{2'b00, 8'h01, 8'h82, 0, 8'h00, 0, 0};
      vt[15] = '{2'b11, 8'h81, 8'h00, 1, 8'hF8, 0, 1};

      pool = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h7C, 8'hFF, 8'h38, 8'hB8, 8'h01, 8'h77};

      RST = 1; IN_VALID = 0; OUT_READY = 0; FLAG_CLR = 0;
      FP_OPERATION = 0; OP_A = 0; OP_B = 0;
      m_nv = 0; m_dz = 0; m_cnt = 0;
      repeat (2) @(posedge CLK);
      #1;
      check_reset_state("reset_in");
      RST = 0;
      @(posedge CLK); #1;
      check_reset_state("reset_out");

      // MUL 38*40 first: must leave flags untouched at zero.
      do_op(vt[3].op, vt[3].a, vt[3].b, vt[3].sp, vt[3].res, vt[3].nv, vt[3].dz, 0, 0, 0);

      for (int i = 0; i < 16; i++)
         do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sp, vt[i].res, vt[i].nv, vt[i].dz, 0, 0, 0);

      // Stall 5 cycles with IN_VALID poked; the poke must not start a new op.
      do_op(2'b00, 8'h78, 8'h38, 1, 8'h78, 0, 0, 5, 0, 1);
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         chk("no_ghost_op", {OUT_VALID, IN_READY}, 2'b01);
      end

      // Clear on the same edge as an NV handshake: NV ends set, DZ cleared.
      do_op(2'b00, 8'h78, 8'hF8, 1, 8'h7C, 1, 0, 0, 1, 0);
      chk("clr_same_edge_nv", FLAG_NV, 1);
      FLAG_CLR = 1;
      @(posedge CLK); #1;
      FLAG_CLR = 0;
      m_nv = 0; m_dz = 0;
      chk("clr_alone", {FLAG_NV, FLAG_DZ}, 2'b00);
      chk("clr_keeps_count", EXC_COUNT, m_cnt);

      // Randomized operations, operands biased toward special encodings.
      for (int i = 0; i < 150; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 8'($urandom);
         b  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 8'($urandom);
         r  = ref_model(op, a, b);
         do_op(op, a, b, r[10], r[9:2], r[1], r[0], $urandom_range(0, 2),
               ($urandom_range(0, 7) == 0), 0);
      end

      // Reset while in CLASSIFY drops the request and clears all state.
      FP_OPERATION = 2'b00; OP_A = 8'h78; OP_B = 8'hF8; IN_VALID = 1;
      @(posedge CLK); #1;
      IN_VALID = 0;
      RST = 1;
      #2;
      chk("rst_mid_async", {IN_READY, OUT_VALID}, 2'b10);
      RST = 0;
      m_nv = 0; m_dz = 0; m_cnt = 0;
      check_reset_state("rst_mid_state");
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         chk("rst_mid_no_rsp", {OUT_VALID, EXC_COUNT}, 9'h000);
      end

      // Counter saturation: 257 NV ops, count stops at FF.
      for (int i = 0; i < 257; i++)
         do_op(2'b00, 8'h78, 8'hF8, 1, 8'h7C, 1, 0, 0, 0, 0);
      chk("count_saturated", EXC_COUNT, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
